// File: rtl/rv_mem_pkg.sv
// Shared types and byte-lane helpers for the rv data memory.
// Misaligned-access trapping is selected in rv_mem_ctrl by RV_MEM_MISALIGN_TRAP_EN.
package rv_mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    RSVD = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } mem_state_t;

  function automatic logic [3:0] strb_mask(mem_size_t size, logic [1:0] lane);
    case (size)
      BYTE:    strb_mask = 4'b0001 << lane;
      HALF:    strb_mask = lane[1] ? 4'b1100 : 4'b0011;
      default: strb_mask = 4'b1111;
    endcase
  endfunction

  // Right-aligned store data is replicated so every candidate lane carries it.
  function automatic logic [31:0] store_lanes(mem_size_t size, logic [31:0] wdata);
    case (size)
      BYTE:    store_lanes = {4{wdata[7:0]}};
      HALF:    store_lanes = {2{wdata[15:0]}};
      default: store_lanes = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(logic [31:0] word, mem_size_t size,
                                               logic [1:0] lane, logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      BYTE:    load_extract = {{24{~uns & b[7]}}, b};
      HALF:    load_extract = {{16{~uns & h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

endpackage

// File: rtl/rv_mem_if.sv
// Valid/ready request and response channel between the core load/store path and rv_mem_ctrl.
interface rv_mem_if
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  mem_size_t         req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/rv_mem_array.sv
// Byte-strobed word storage: synchronous write, registered read (1 cycle), no backpressure.
// Array is named mem so benches can reach it hierarchically.
module rv_mem_array #(
  parameter int DEPTH_WORDS = 8192,
  parameter int IDX_W       = 13
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       wstrb,
  input  logic             re,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);
  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[idx];
  end
endmodule

// File: rtl/rv_mem_ctrl.sv
// Single-outstanding RISC-V data memory; rsp_valid rises LATENCY edges after accept, held until rsp_ready.
// req_ready = IDLE || (RESP && rsp_ready). RV_MEM_MISALIGN_TRAP_EN makes misaligned/reserved accesses fault.
module rv_mem_ctrl
  import rv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 8192,
  parameter int ADDR_W      = 32,
  parameter int LATENCY     = 1
) (
  input logic     clk,
  input logic     rst,
  rv_mem_if.slave bus
);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  mem_state_t  state;
  logic [1:0]  cnt;
  logic        accept;
  mem_size_t   size_eff;
  logic [1:0]  lane_eff;
  logic        mis;
  mem_size_t   size_q;
  logic [1:0]  lane_q;
  logic        uns_q;
  logic        load_q;
  logic        err_q;
  logic [31:0] arr_rdata;
  logic        unused_addr;

  assign unused_addr   = ^bus.req_addr;
  assign bus.req_ready = (state == ST_IDLE) || ((state == ST_RESP) && bus.rsp_ready);
  assign accept        = rst && bus.req_valid && bus.req_ready;

  always_comb begin
    size_eff = bus.req_size;
    lane_eff = bus.req_addr[1:0];
    mis      = 1'b0;
`ifdef RV_MEM_MISALIGN_TRAP_EN
    case (size_eff)
      HALF:    mis = lane_eff[0];
      WORD:    mis = |lane_eff;
      RSVD:    mis = 1'b1;
      default: mis = 1'b0;
    endcase
`else
    if (size_eff == RSVD) size_eff = WORD;
    case (size_eff)
      HALF:    lane_eff[0] = 1'b0;
      WORD:    lane_eff    = 2'b00;
      default: lane_eff    = bus.req_addr[1:0];
    endcase
`endif
  end

  // Stores commit on the accept edge, so a load accepted next cycle reads the new bytes.
  rv_mem_array #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .we    (accept && bus.req_write && !mis),
    .wstrb (strb_mask(size_eff, lane_eff)),
    .re    (accept && !bus.req_write && !mis),
    .idx   (bus.req_addr[2 +: IDX_W]),
    .wdata (store_lanes(size_eff, bus.req_wdata)),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= 2'd0;
      size_q <= WORD;
      lane_q <= 2'b00;
      uns_q  <= 1'b0;
      load_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      size_q <= size_eff;
      lane_q <= lane_eff;
      uns_q  <= bus.req_unsigned;
      load_q <= !bus.req_write && !mis;
      err_q  <= mis;
      cnt    <= (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;
      state  <= (LATENCY > 1) ? ST_WAIT : ST_RESP;
    end else begin
      case (state)
        ST_WAIT: begin
          if (cnt == 2'd0) state <= ST_RESP;
          else             cnt   <= cnt - 2'd1;
        end
        ST_RESP: if (bus.rsp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Response data derives only from registers, so it holds steady while stalled.
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_rdata = ((state == ST_RESP) && load_q) ?
                         load_extract(arr_rdata, size_q, lane_q, uns_q) : 32'd0;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_rv_mem_ctrl.sv
// Bench for rv_mem_ctrl: LATENCY=1 and LATENCY=3 instances against a byte-array reference model.
module tb_rv_mem_ctrl;
  import rv_mem_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 32;
  localparam int NB    = DEPTH * 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic        rdy;
  } drv_t;

  typedef struct packed {
    logic        w;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  drv_t        drv [2];
  logic        mon_valid [2];
  logic        mon_ready [2];
  logic        mon_err [2];
  logic [31:0] mon_rdata [2];
  logic [7:0]  mm [2][NB];
  vec_t        tbl [20];
  int          checks = 0;
  int          errors = 0;

  rv_mem_if #(.ADDR_W(AW)) b1 ();
  rv_mem_if #(.ADDR_W(AW)) b3 ();

  rv_mem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  rv_mem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW), .LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  assign b1.req_valid = drv[0].valid;    assign b3.req_valid = drv[1].valid;
  assign b1.req_write = drv[0].write;    assign b3.req_write = drv[1].write;
  assign b1.req_addr  = drv[0].addr;     assign b3.req_addr  = drv[1].addr;
  assign b1.req_size  = mem_size_t'(drv[0].size);
  assign b3.req_size  = mem_size_t'(drv[1].size);
  assign b1.req_unsigned = drv[0].uns;   assign b3.req_unsigned = drv[1].uns;
  assign b1.req_wdata = drv[0].wdata;    assign b3.req_wdata = drv[1].wdata;
  assign b1.rsp_ready = drv[0].rdy;      assign b3.rsp_ready = drv[1].rdy;
  assign mon_valid[0] = b1.rsp_valid;    assign mon_valid[1] = b3.rsp_valid;
  assign mon_ready[0] = b1.req_ready;    assign mon_ready[1] = b3.req_ready;
  assign mon_err[0]   = b1.rsp_err;      assign mon_err[1]   = b3.rsp_err;
  assign mon_rdata[0] = b1.rsp_rdata;    assign mon_rdata[1] = b3.rsp_rdata;

  function automatic int lat_of(int s);
    return (s == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] pre(int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: memory as a flat byte array, accesses as n consecutive bytes.
  task automatic model(input int s, input logic w, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic err);
    int n, lane, base;
    logic [31:0] v;
    n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    lane = int'(addr % 4);
`ifdef RV_MEM_MISALIGN_TRAP_EN
    err = (size == 2'd3) || (lane % n != 0);
`else
    err  = 1'b0;
    lane = lane - (lane % n);
`endif
    base = int'((addr / 4) % DEPTH) * 4 + lane;
    rd   = 32'd0;
    if (!err) begin
      if (w) begin
        for (int k = 0; k < n; k++) mm[s][base + k] = wdata[8*k +: 8];
      end else begin
        v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(mm[s][base + k]) << (8 * k));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        rd = v;
      end
    end
  endtask

  task automatic txn(input int s, input logic w, input logic [31:0] addr, input logic [1:0] size,
                     input logic uns, input logic [31:0] wdata,
                     output logic [31:0] rd, output logic err, output int lat);
    @(negedge clk);
    drv[s].valid = 1'b1; drv[s].write = w; drv[s].addr = addr;
    drv[s].size = size;  drv[s].uns = uns; drv[s].wdata = wdata; drv[s].rdy = 1'b1;
    @(posedge clk); #1;
    // Scramble the request fields: the DUT must have captured them at accept.
    drv[s].valid = 1'b0; drv[s].write = 1'($urandom); drv[s].addr = $urandom;
    drv[s].size = 2'($urandom); drv[s].uns = 1'($urandom); drv[s].wdata = $urandom;
    lat = 1;
    while (!mon_valid[s] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = mon_rdata[s];
    err = mon_err[s];
    @(posedge clk); #1;
  endtask

  task automatic run(input int s, input string name, input logic w, input logic [31:0] addr,
                     input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    int          lat;
    txn(s, w, addr, size, uns, wdata, rd, err, lat);
    check({name, " latency"}, 32'(lat), 32'(lat_of(s)));
    check({name, " rdata"}, rd, exp_rd);
    check({name, " err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic run_model(input int s, input string name, input logic w, input logic [31:0] addr,
                           input logic [1:0] size, input logic uns, input logic [31:0] wdata);
    logic [31:0] e_rd;
    logic        e_err;
    model(s, w, addr, size, uns, wdata, e_rd, e_err);
    run(s, name, w, addr, size, uns, wdata, e_rd, e_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] e_rd, e_a, e_b;
    logic        e_err;
    int          lat;

    for (int s = 0; s < 2; s++) begin
      drv[s] = '0;
      drv[s].rdy = 1'b1;
    end

    tbl[0]  = '{1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h13, 2'd0, 1'b0, 32'hFFFFFF5A, 32'h0, 1'b0};
    tbl[3]  = '{1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'h5AADBEEF, 1'b0};
    tbl[4]  = '{1'b0, 32'h11, 2'd0, 1'b0, 32'h0, 32'hFFFFFFBE, 1'b0};
    tbl[5]  = '{1'b0, 32'h11, 2'd0, 1'b1, 32'h0, 32'h000000BE, 1'b0};
    tbl[6]  = '{1'b1, 32'h20, 2'd2, 1'b0, 32'h80010000, 32'h0, 1'b0};
    tbl[7]  = '{1'b0, 32'h22, 2'd1, 1'b0, 32'h0, 32'hFFFF8001, 1'b0};
    tbl[8]  = '{1'b0, 32'h22, 2'd1, 1'b1, 32'h0, 32'h00008001, 1'b0};
    tbl[9]  = '{1'b1, 32'h16, 2'd1, 1'b0, 32'h1234ABCD, 32'h0, 1'b0};
    tbl[10] = '{1'b0, 32'h14, 2'd2, 1'b0, 32'h0, 32'hABCD0A0F, 1'b0};
    tbl[12] = '{1'b1, 32'h100, 2'd2, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0};
    tbl[13] = '{1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0};
`ifdef RV_MEM_MISALIGN_TRAP_EN
    tbl[11] = '{1'b0, 32'h2, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1};
    tbl[14] = '{1'b1, 32'h2, 2'd2, 1'b0, 32'h11111111, 32'h0, 1'b1};
    tbl[15] = '{1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0};
    tbl[16] = '{1'b0, 32'h4, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1};
    tbl[17] = '{1'b0, 32'h23, 2'd1, 1'b1, 32'h0, 32'h0, 1'b1};
    tbl[18] = '{1'b1, 32'h9, 2'd1, 1'b0, 32'h0000BEEF, 32'h0, 1'b1};
    tbl[19] = '{1'b0, 32'h8, 2'd2, 1'b0, 32'h0, 32'h10020406, 1'b0};
`else
    tbl[11] = '{1'b0, 32'h2, 2'd2, 1'b0, 32'h0, 32'h10000000, 1'b0};
    tbl[14] = '{1'b1, 32'h2, 2'd2, 1'b0, 32'h11111111, 32'h0, 1'b0};
    tbl[15] = '{1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 32'h11111111, 1'b0};
    tbl[16] = '{1'b0, 32'h4, 2'd3, 1'b0, 32'h0, 32'h10010203, 1'b0};
    tbl[17] = '{1'b0, 32'h23, 2'd1, 1'b1, 32'h0, 32'h00008001, 1'b0};
    tbl[18] = '{1'b1, 32'h9, 2'd1, 1'b0, 32'h0000BEEF, 32'h0, 1'b0};
    tbl[19] = '{1'b0, 32'h8, 2'd2, 1'b0, 32'h0, 32'h1002BEEF, 1'b0};
`endif

    // Reset state on both instances.
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check("reset rsp_valid", 32'(mon_valid[s]), 32'd0);
      check("reset rsp_rdata", mon_rdata[s], 32'd0);
      check("reset rsp_err", 32'(mon_err[s]), 32'd0);
      check("reset req_ready", 32'(mon_ready[s]), 32'd1);
    end
    @(negedge clk) rst = 1'b1;

    // Fill the LATENCY=1 memory with a known pattern, then the directed table.
    for (int i = 0; i < DEPTH; i++) run_model(0, "preload", 1'b1, 32'(i * 4), 2'd2, 1'b0, pre(i));
    for (int i = 0; i < 20; i++) begin
      model(0, tbl[i].w, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata, e_rd, e_err);
      run(0, $sformatf("vec%0d", i), tbl[i].w, tbl[i].addr, tbl[i].size, tbl[i].uns,
          tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_err);
    end

    // Back-to-back loads at LATENCY=1: second accept happens in RESP with rsp_ready=1.
    model(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, e_a, e_err);
    model(0, 1'b0, 32'h22, 2'd1, 1'b0, 32'h0, e_b, e_err);
    @(negedge clk);
    drv[0] = '{1'b1, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 1'b1};
    @(posedge clk); #1;
    drv[0].addr = 32'h22; drv[0].size = 2'd1;
    check("b2b first valid", 32'(mon_valid[0]), 32'd1);
    check("b2b first rdata", mon_rdata[0], e_a);
    check("b2b ready in resp", 32'(mon_ready[0]), 32'd1);
    @(posedge clk); #1;
    drv[0].valid = 1'b0;
    check("b2b second valid", 32'(mon_valid[0]), 32'd1);
    check("b2b second rdata", mon_rdata[0], e_b);
    @(posedge clk); #1;
    check("b2b drained", 32'(mon_valid[0]), 32'd0);

    // Randomized traffic, including wrapping addresses and reserved sizes.
    for (int i = 0; i < 400; i++) begin
      run_model(0, $sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 2 * NB - 1)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
    end

    // LATENCY=3: stall the response and queue a second request behind it.
    run_model(1, "l3 store", 1'b1, 32'h40, 2'd2, 1'b0, 32'h01234567);
    @(negedge clk);
    drv[1] = '{1'b1, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 1'b0};
    @(posedge clk); #1;
    drv[1].addr = 32'h41; drv[1].size = 2'd0; drv[1].uns = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("stall%0d req_ready", k), 32'(mon_ready[1]), 32'd0);
      check($sformatf("stall%0d rsp_valid", k), 32'(mon_valid[1]), 32'(k >= 3));
      if (k >= 3) check($sformatf("stall%0d rdata", k), mon_rdata[1], 32'h01234567);
      @(posedge clk); #1;
    end
    @(negedge clk) drv[1].rdy = 1'b1;
    #1 check("release req_ready", 32'(mon_ready[1]), 32'd1);
    @(posedge clk); #1;
    drv[1].valid = 1'b0;
    check("same-cycle accept valid drop", 32'(mon_valid[1]), 32'd0);
    lat = 1;
    while (!mon_valid[1] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("queued latency", 32'(lat), 32'd3);
    check("queued rdata", mon_rdata[1], 32'h00000045);
    @(posedge clk); #1;

    // A store presented on a reset edge must not commit.
    run_model(1, "l3 store2", 1'b1, 32'h48, 2'd2, 1'b0, 32'h600DCAFE);
    @(negedge clk);
    drv[1] = '{1'b1, 1'b1, 32'h48, 2'd2, 1'b0, 32'hBAD0BAD0, 1'b1};
    rst = 1'b0;
    @(posedge clk); #1;
    drv[1].valid = 1'b0;
    check("rst store rsp_valid", 32'(mon_valid[1]), 32'd0);
    @(negedge clk) rst = 1'b1;
    run_model(1, "rst store dropped", 1'b0, 32'h48, 2'd2, 1'b0, 32'h0);

    // Reset during WAIT discards the pending response.
    @(negedge clk);
    drv[1] = '{1'b1, 1'b0, 32'h48, 2'd2, 1'b0, 32'h0, 1'b1};
    @(posedge clk); #1;
    drv[1] = '{1'b1, 1'b1, 32'h48, 2'd2, 1'b0, 32'h0BADBEEF, 1'b1};
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    drv[1].valid = 1'b0;
    check("wait rst rsp_valid", 32'(mon_valid[1]), 32'd0);
    check("wait rst req_ready", 32'(mon_ready[1]), 32'd1);
    @(negedge clk) rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("discarded rsp %0d", k), 32'(mon_valid[1]), 32'd0);
    end
    run_model(1, "wait rst no write", 1'b0, 32'h48, 2'd2, 1'b0, 32'h0);
    run_model(1, "l3 half signed", 1'b0, 32'h42, 2'd1, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv_mem_ctrl.md
# rv_mem_ctrl

Parametrised, byte-addressable RISC-V data memory with a valid/ready request and response handshake. Supports byte, halfword and word loads and stores, with sign/zero extension and byte-lane write strobes. Read latency is configurable. Sits between the `rv` core's load/store path and storage, replacing the fixed-size, combinational-read word memory. Test benches preload the storage array hierarchically.

## Interface
Parameters:
- `DEPTH_WORDS`, 8192: storage depth in 32-bit words; must be a power of 2.
- `ADDR_W`, 32: byte-address width.
- `LATENCY`, 1: cycles from request accept to `rsp_valid`; legal range 1..4.

Ports:
- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  reset; synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready` at posedge.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  `ADDR_W`  byte address.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0.
- `req_wdata`  in  32  store data, right-aligned (bits [7:0] for byte, [15:0] for half).
- `rsp_valid`  out  1  response present; held until `rsp_ready`.
- `rsp_ready`  in  1  response consumed when `rsp_valid && rsp_ready` at posedge.
- `rsp_rdata`  out  32  load result, extended to 32 bits; 0 for stores and errors.
- `rsp_err`  out  1  access faulted (see Configuration); meaningful only with `rsp_valid`.

## Operation
- Address decode:
  - Word index = `req_addr[ADDR_W-1:2]` modulo `DEPTH_WORDS`; out-of-range addresses wrap silently.
  - Lane = `req_addr[1:0]`.
- Stores:
  - Byte stores replicate into the addressed lane with a one-hot strobe.
  - Half stores write lanes {1,0} or {3,2}, selected by `addr[1]`.
  - Word stores write all 4 lanes.
  - Non-strobed bytes are untouched. There is no read-modify-write hazard; storage is byte-strobed.
- Loads:
  - Select the addressed byte or half from the word.
  - Extend to 32 bits per `req_unsigned`; `req_unsigned` is ignored for word loads.
- FSM states:
  - IDLE: `req_ready`=1. On accept, go to WAIT if `LATENCY`>1, otherwise go to RESP.
  - WAIT: a down-counter runs from `LATENCY`-2. At zero, go to RESP.
  - RESP: `rsp_valid`=1. On `rsp_ready`, go to IDLE, or accept a new request in the same cycle (see below).
- Back-to-back: `req_ready` = IDLE || (RESP && `rsp_ready`). An accept in RESP goes directly to WAIT or RESP for the new request, so sustained throughput is one access per `LATENCY` cycles.
- Only one request is outstanding. Request fields are captured at accept; later changes to the inputs are ignored.
- Stores commit to storage at the accept edge. Every store also produces a response: `rsp_rdata`=0, with `rsp_err` set as applicable.
- Ordering: a load accepted after a store returns the stored data, including a load accepted on the cycle right after the store.

## Timing
- Reset (`rst`=0 at posedge):
  - FSM goes to IDLE, counter clears.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `req_ready` reads 1 from the first cycle after reset.
  - Storage contents are not reset.
- Reset has priority over accept. A store presented on a reset edge does not commit. A pending response is discarded.
- `rsp_valid` rises exactly `LATENCY` posedges after the accept edge.
- `rsp_rdata` and `rsp_err` are registered and stable while `rsp_valid`=1 and `rsp_ready`=0.
- No combinational path from `req_*` to `rsp_*`. `req_ready` depends combinationally only on the FSM state and `rsp_ready`.

## Configuration
- Macro: `RV_MEM_MISALIGN_TRAP_EN`.
- Defined:
  - These accesses raise `rsp_err`=1: half with `addr[0]`=1, word with `addr[1:0]`≠0, or `req_size`=11.
  - No storage is written and `rsp_rdata`=0.
  - Latency and handshake are unchanged.
- Undefined:
  - Low address bits are forced aligned: half ignores `addr[0]`, word ignores `addr[1:0]`.
  - `req_size`=11 is treated as word.
  - `rsp_err` is tied 0.

## Structure
- Package `rv_mem_pkg`:
  - `mem_size_t` enum (BYTE, HALF, WORD, RSVD).
  - FSM state enum.
  - Functions for the strobe mask and load extraction/extension.
- Sub-module `rv_mem_array`:
  - `DEPTH_WORDS`×32 storage, 4-bit byte strobe, synchronous write, registered read.
  - Array name `mem`, so benches can preload it hierarchically.
- `rv_mem_ctrl` holds the handshake FSM, latency counter, decode and response registers.

## Test plan
- Reset, then store word 0xDEADBEEF @0x10, then load word @0x10 with `LATENCY`=1 → `rsp_valid` 1 cycle after accept; rdata 0xDEADBEEF; err 0.
- Store byte 0x5A @0x13 over 0xDEADBEEF, then load word @0x10 → 0x5AADBEEF. Load byte signed @0x11 → 0xFFFFFFBE. Load byte unsigned @0x11 → 0x000000BE.
- Load half @0x12 signed/unsigned from word 0x8001_0000 → 0xFFFF8001 / 0x00008001.
- `LATENCY`=3, `rsp_ready` held 0 for 5 cycles → `rsp_valid` at accept+3 with data stable, `req_ready`=0 throughout. Then `rsp_ready`=1 with a new `req_valid` → new accept in the same cycle.
- Load word @0x2 → with the macro: err=1, rdata=0, no write; without the macro: data of word 0x0. Store word @(`DEPTH_WORDS`×4) → lands in word 0.
- Assert `rst`=0 in the cycle a store is presented, during WAIT → no write, `rsp_valid`=0 the next cycle, `req_ready`=1.
